// File: rtl/draw_sweep_ctrl.sv
// Draw-path address sweep sequencer: walks a range of pair indices, issuing
// one even/odd write pair per accepted mem_ready, with start/busy/done/abort.
module draw_sweep_ctrl #(
  parameter int IDX_W  = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  base_idx,
  input  logic [IDX_W:0]    count,
  input  logic [DATA_W-1:0] color,
  input  logic              abort,
  input  logic              mem_ready,
  output logic              we,
  output logic [IDX_W:0]    addr_a,
  output logic [IDX_W:0]    addr_b,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [IDX_W:0]    pairs_written
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   CNT_ZERO = {(IDX_W+1){1'b0}};
  localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W:0]      remain_q, remain_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [IDX_W:0]      pw_q, pw_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept_s;
  logic                finish_s;

  assign accept_s = (state_q == S_WRITE) && mem_ready;
  // The sweep ends on the last accepted pair or on abort, whichever comes first.
  assign finish_s = (state_q == S_WRITE) && (abort || (mem_ready && (remain_q == CNT_ONE)));

  // Next-state and next-output computation.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    remain_d = remain_q;
    wdata_d  = wdata_q;
    pw_d     = pw_q;
    we_d     = we_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pw_d = CNT_ZERO;
          if (count != CNT_ZERO) begin
            state_d  = S_WRITE;
            idx_d    = base_idx;
            remain_d = count;
            wdata_d  = color;
            we_d     = 1'b1;
            busy_d   = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          we_d   = 1'b0;
          busy_d = 1'b0;
        end
      end
      S_WRITE: begin
        if (accept_s) begin
          idx_d    = idx_q + IDX_ONE;
          remain_d = remain_q - CNT_ONE;
          pw_d     = pw_q + CNT_ONE;
        end else begin
          idx_d    = idx_q;
          remain_d = remain_q;
        end
        if (finish_s) begin
          state_d = S_DONE;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          we_d   = 1'b1;
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= IDX_ZERO;
      remain_q <= CNT_ZERO;
      wdata_q  <= {DATA_W{1'b0}};
      pw_q     <= CNT_ZERO;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      remain_q <= remain_d;
      wdata_q  <= wdata_d;
      pw_q     <= pw_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign we            = we_q;
  assign addr_a        = {idx_q, 1'b0};
  assign addr_b        = {idx_q, 1'b1};
  assign wdata         = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pairs_written = pw_q;

endmodule

// File: tb/tb_draw_sweep_ctrl.sv
// Bench for draw_sweep_ctrl: table of sweep scenarios checked against an
// address scoreboard, plus hand-written reset, idle-abort and restart sequences.
module tb_draw_sweep_ctrl;

  localparam int IDX_W  = 13;
  localparam int DATA_W = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic [IDX_W-1:0]  base_idx;
  logic [IDX_W:0]    count;
  logic [DATA_W-1:0] color;
  logic              abort;
  logic              mem_ready;
  logic              we;
  logic [IDX_W:0]    addr_a;
  logic [IDX_W:0]    addr_b;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [IDX_W:0]    pairs_written;

  int checks = 0;
  int errors = 0;

  logic [IDX_W:0] sb[$];

  typedef struct {
    logic [IDX_W-1:0]  base;
    logic [IDX_W:0]    cnt;
    logic [DATA_W-1:0] col;
    int                stall;     // 0 always ready, 1 alternate, 2 random
    int                abort_at;  // 0: no abort, else abort on that accept
    int                exp_n;
    logic              spurious;  // pulse start while running / in done
  } sweep_t;

  draw_sweep_ctrl #(.IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_idx(base_idx),
    .count(count), .color(color), .abort(abort), .mem_ready(mem_ready),
    .we(we), .addr_a(addr_a), .addr_b(addr_b), .wdata(wdata),
    .busy(busy), .done(done), .pairs_written(pairs_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, 32'(we), 32'd0);
    chk({tag, "_addr_a"}, 32'(addr_a), 32'd0);
    chk({tag, "_addr_b"}, 32'(addr_b), 32'd1);
    chk({tag, "_wdata"}, 32'(wdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pw"}, 32'(pairs_written), 32'd0);
  endtask

  task automatic run_sweep(input sweep_t v);
    int accepts = 0;
    int ndone = 0;
    int cyc = 0;
    int tail = 0;
    logic chk_end = 1'b0;
    logic chk_stall = 1'b0;
    logic alt = 1'b0;
    logic rdy;
    logic [IDX_W:0] prev_a = '0;
    logic [IDX_W:0] prev_pw = '0;
    logic [IDX_W:0] exp_a;
    logic [IDX_W-1:0] idx;
    sb.delete();
    for (int i = 0; i < v.exp_n; i++) begin
      idx = v.base + IDX_W'(i);
      sb.push_back({idx, 1'b0});
    end
    @(negedge clk);
    start = 1'b1; base_idx = v.base; count = v.cnt; color = v.col;
    mem_ready = 1'b0; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("first_we", 32'(we), 32'(v.cnt != '0));
    chk("first_done", 32'(done), 32'(v.cnt == '0));
    while (cyc < 3000) begin
      if (chk_end) begin
        chk("end_we", 32'(we), 32'd0);
        chk("end_done", 32'(done), 32'd1);
        chk_end = 1'b0;
      end
      if (chk_stall) begin
        chk("stall_addr", 32'(addr_a), 32'(prev_a));
        chk("stall_pw", 32'(pairs_written), 32'(prev_pw));
        chk_stall = 1'b0;
      end
      if (done) ndone++;
      if (we) begin
        chk("wdata", 32'(wdata), 32'(v.col));
        chk("busy", 32'(busy), 32'd1);
        case (v.stall)
          1: begin rdy = alt; alt = ~alt; end
          2: rdy = 1'($urandom_range(0, 1));
          default: rdy = 1'b1;
        endcase
        mem_ready = rdy;
        if (rdy) begin
          if (sb.size() == 0) begin
            chk("extra_accept", 32'(addr_a), 32'hFFFF);
          end else begin
            exp_a = sb.pop_front();
            chk("addr_a", 32'(addr_a), 32'(exp_a));
            chk("addr_b", 32'(addr_b), 32'(exp_a | 14'd1));
          end
          accepts++;
          if (accepts == v.exp_n) begin
            chk_end = 1'b1;
            if (v.abort_at != 0) abort = 1'b1;
          end
        end else begin
          chk_stall = 1'b1;
          prev_a = addr_a;
          prev_pw = pairs_written;
        end
      end else begin
        mem_ready = 1'b0;
        abort = 1'b0;
        if (ndone > 0) tail++;
        if (tail >= 3) break;
      end
      if (v.spurious) begin
        start = we | done;
        base_idx = 13'd777;
        count = 14'd9;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; mem_ready = 1'b0; abort = 1'b0;
    chk("timeout", 32'(cyc >= 3000), 32'd0);
    chk("accepts", 32'(accepts), 32'(v.exp_n));
    chk("done_pulses", 32'(ndone), 32'd1);
    chk("pairs_written", 32'(pairs_written), 32'(v.exp_n));
    chk("idle_busy", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  sweep_t tbl[7];

  initial begin
    tbl[0] = '{13'd4096, 14'd1024, 8'h3C, 0, 0, 1024, 1'b0};
    tbl[1] = '{13'd10,   14'd3,    8'hA5, 1, 0, 3,    1'b0};
    tbl[2] = '{13'd8191, 14'd3,    8'h77, 0, 0, 3,    1'b0};
    tbl[3] = '{13'd0,    14'd100,  8'h11, 0, 5, 5,    1'b0};
    tbl[4] = '{13'd55,   14'd0,    8'h22, 0, 0, 0,    1'b0};
    tbl[5] = '{13'd100,  14'd4,    8'h5A, 0, 0, 4,    1'b1};
    tbl[6] = '{13'd8188, 14'd9,    8'hFF, 2, 0, 9,    1'b0};

    reset = 1'b0; start = 1'b0; base_idx = '0; count = '0; color = '0;
    abort = 1'b0; mem_ready = 1'b0;
    #12;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_rel");

    for (int t = 0; t < 7; t++) run_sweep(tbl[t]);

    // abort while idle must not produce any activity
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_done", 32'(done), 32'd0);
    chk("idle_abort_we", 32'(we), 32'd0);

    // reset in the middle of a long sweep, observed without a clock edge
    @(negedge clk);
    start = 1'b1; base_idx = 13'd0; count = 14'd1024; color = 8'h99; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 49; i++) @(negedge clk);
    chk("pre_rst_addr", 32'(addr_a), 32'd98);
    #2 reset = 1'b0;
    #1 chk_reset_vals("mid_rst");
    @(negedge clk);
    chk_reset_vals("mid_rst_hold");
    reset = 1'b1; mem_ready = 1'b0;
    run_sweep('{13'd300, 14'd20, 8'h42, 2, 0, 20, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
